// File: rtl/mem_req_ctrl.sv
// CPU-side memory access controller: aligns a load/store onto a 32-bit memory port,
// holds the request until ack or timeout, and returns a one-cycle ready/err pulse.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic             r_write, w_write;
  logic [CNT_W-1:0] r_wait, w_wait;
  logic             r_ready, w_ready;
  logic             r_err, w_err;
  logic [31:0]      r_rdata, w_rdata;
  logic             r_mem_req, w_mem_req;
  logic             r_mem_we, w_mem_we;
  logic [3:0]       r_mem_be, w_mem_be;
  logic [31:0]      r_mem_addr, w_mem_addr;
  logic [31:0]      r_mem_wdata, w_mem_wdata;

  logic             w_illegal;
  logic [3:0]       w_lane_be;

  // Lane decode of the incoming CPU request
  always_comb begin
    w_illegal = 1'b0;
    w_lane_be = 4'h0;
    case (size)
      2'd0: w_lane_be = 4'b0001 << addr[1:0];
      2'd1: begin
        w_lane_be = 4'b0011 << addr[1:0];
        w_illegal = addr[0];
      end
      2'd2: begin
        w_lane_be = 4'b1111;
        w_illegal = (addr[1:0] != 2'b00);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    w_state     = r_state;
    w_write     = r_write;
    w_wait      = r_wait;
    w_ready     = 1'b0;
    w_err       = 1'b0;
    w_rdata     = 32'h0;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_be    = r_mem_be;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_write = write;
          if (w_illegal) begin
            w_state = S_DONE;
            w_ready = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_state     = S_REQ;
            w_wait      = '0;
            w_mem_req   = 1'b1;
            w_mem_we    = write;
            w_mem_be    = w_lane_be;
            w_mem_addr  = {addr[31:2], 2'b00};
            w_mem_wdata = wdata << {addr[1:0], 3'b000};
          end
        end
      end
      S_REQ: begin
        if (mem_ack || (r_wait == LAST_WAIT)) begin
          // ack takes priority over a coinciding timeout
          w_state     = S_DONE;
          w_ready     = 1'b1;
          w_err       = ~mem_ack;
          w_rdata     = (mem_ack && !r_write) ? mem_rdata : 32'h0;
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_mem_be    = 4'h0;
          w_mem_addr  = 32'h0;
          w_mem_wdata = 32'h0;
        end
        if (!mem_ack) begin
          w_wait = r_wait + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_wait      <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      r_state     <= w_state;
      r_write     <= w_write;
      r_wait      <= w_wait;
      r_ready     <= w_ready;
      r_err       <= w_err;
      r_rdata     <= w_rdata;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_be    <= w_mem_be;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign ready     = r_ready;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: expected ready results are queued when a request
// is driven and popped when the completion pulse appears.
module tb_mem_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  mem_req_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .write     (write),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_rdata"}, rdata, e.rdata);
    end
  endtask

  task automatic request(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    enable = 1'b1;
    write  = wr;
    size   = sz;
    addr   = a;
    wdata  = wd;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    write     = 1'b0;
    size      = 2'd0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // load word, immediate ack
    request(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    sb_q.push_back('{err: 1'b0, rdata: 32'h1234_5678});
    tick();
    enable = 1'b0;
    chk("lw_mem_req", 32'(mem_req), 32'd1);
    chk("lw_mem_addr", mem_addr, 32'h0000_0100);
    chk("lw_mem_be", 32'(mem_be), 32'hF);
    chk("lw_mem_we", 32'(mem_we), 32'd0);
    chk("lw_ready_early", 32'(ready), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    expect_done("lw");
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("lw_ready_once", 32'(ready), 32'd0);

    // byte store at lane 3, three wait cycles
    request(1'b1, 2'd0, 32'h0000_0203, 32'h0000_00AB);
    sb_q.push_back('{err: 1'b0, rdata: 32'h0});
    mem_rdata = 32'hCAFE_F00D;
    tick();
    enable = 1'b0;
    chk("sb_mem_we", 32'(mem_we), 32'd1);
    chk("sb_mem_addr", mem_addr, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sb_wait_req", 32'(mem_req), 32'd1);
      chk("sb_wait_be", 32'(mem_be), 32'h8);
      chk("sb_wait_wdata", mem_wdata, 32'hAB00_0000);
      chk("sb_wait_ready", 32'(ready), 32'd0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_done("sb");
    tick();

    // half store at upper lanes
    request(1'b1, 2'd1, 32'h0000_0102, 32'h0000_1234);
    sb_q.push_back('{err: 1'b0, rdata: 32'h0});
    tick();
    enable = 1'b0;
    chk("sh_mem_be", 32'(mem_be), 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'h1234_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_done("sh");
    tick();

    // misaligned half, with a stray ack in DONE
    request(1'b0, 2'd1, 32'h0000_0101, 32'h0);
    sb_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();
    enable  = 1'b0;
    mem_ack = 1'b1;
    expect_done("mis");
    chk("mis_mem_req", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("mis_ack_ignored", 32'(ready), 32'd0);
    chk("mis_no_req", 32'(mem_req), 32'd0);

    // reserved size
    request(1'b0, 2'd3, 32'h0000_0000, 32'h0);
    sb_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();
    enable = 1'b0;
    expect_done("rsv");
    chk("rsv_mem_req", 32'(mem_req), 32'd0);
    tick();

    // timeout with no ack
    begin
      int cnt;
      cnt = 0;
      request(1'b0, 2'd2, 32'h0000_0040, 32'h0);
      sb_q.push_back('{err: 1'b1, rdata: 32'h0});
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      enable = 1'b0;
      while (mem_req === 1'b1 && cnt < 10) begin
        cnt++;
        tick();
      end
      chk("to_req_cycles", 32'(cnt), 32'd4);
      expect_done("to");
      tick();
    end

    // ack coinciding with the timeout cycle
    request(1'b0, 2'd2, 32'h0000_0044, 32'h0);
    sb_q.push_back('{err: 1'b0, rdata: 32'h55AA_1234});
    tick();
    enable = 1'b0;
    tick();
    tick();
    tick();
    chk("toack_req_c4", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA_1234;
    tick();
    mem_ack = 1'b0;
    expect_done("toack");
    tick();

    // reset in the second REQ cycle, then a stale ack
    request(1'b0, 2'd2, 32'h0000_0080, 32'h0);
    tick();
    enable = 1'b0;
    tick();
    chk("rr_req_c2", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_req_drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rr_stale_ready", 32'(ready), 32'd0);
    tick();
    chk("rr_stale_ready2", 32'(ready), 32'd0);

    // back-to-back loads with enable held
    request(1'b0, 2'd2, 32'h0000_0000, 32'h0);
    sb_q.push_back('{err: 1'b0, rdata: 32'h1111_1111});
    tick();
    chk("b2b1_mem_addr", mem_addr, 32'h0000_0000);
    chk("b2b1_mem_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    addr      = 32'h0000_0004;
    tick();
    mem_ack = 1'b0;
    expect_done("b2b1");
    tick();
    chk("b2b_idle_ready", 32'(ready), 32'd0);
    chk("b2b_idle_req", 32'(mem_req), 32'd0);
    sb_q.push_back('{err: 1'b0, rdata: 32'h2222_2222});
    tick();
    enable = 1'b0;
    chk("b2b2_mem_addr", mem_addr, 32'h0000_0004);
    chk("b2b2_mem_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    expect_done("b2b2");
    tick();
    chk("b2b_end_ready", 32'(ready), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum mem_req cycles waited for mem_ack (range 1..255).
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- enable  input  1  CPU access request; held high while the CPU is stalled
- write  input  1  1=store, 0=load; sampled with enable
- size  input  2  0=byte, 1=half, 2=word, 3=reserved
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- ready  output  1  one-cycle completion pulse; feeds the stall controller's IM_ready/DM_ready
- rdata  output  32  raw 32-bit word read; valid while ready=1
- err  output  1  one-cycle pulse with ready on misalignment, reserved size or timeout
- mem_req  output  1  memory-side request; held until ack
- mem_we  output  1  memory write strobe
- mem_be  output  4  byte enables
- mem_addr  output  32  word address; bits [1:0] always 0
- mem_wdata  output  32  store data shifted into byte lanes
- mem_ack  input  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  input  32  memory read word

Function
REQ-003 The FSM SHALL have states IDLE, REQ and DONE; all outputs SHALL be registered.
REQ-004 In IDLE with enable=1, the block SHALL latch write, size, addr and wdata; it SHALL then go to REQ if the request is legal, or to DONE with err set if it is illegal.
REQ-005 A request SHALL be illegal for size=3, for size=1 with addr[0]=1, and for size=2 with addr[1:0]!=0; an illegal request SHALL never assert mem_req.
REQ-006 mem_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word.
REQ-007 mem_wdata SHALL be wdata<<(8*addr[1:0]).
REQ-008 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-009 In REQ, mem_req SHALL be 1, and mem_req, mem_we, mem_be, mem_addr and mem_wdata SHALL be stable until ack or timeout.
REQ-010 On mem_ack=1 in REQ, the block SHALL capture mem_rdata into rdata (loads only; stores SHALL leave rdata at 0) and go to DONE; mem_req SHALL be 0 in the next cycle.
REQ-011 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-012 When the wait counter reaches TIMEOUT without ack, the block SHALL deassert mem_req, set rdata to 32'h0, set err, and go to DONE.
REQ-013 If mem_ack coincides with the timeout cycle, the ack SHALL win and err SHALL be 0.
REQ-014 In DONE, ready SHALL be 1 for exactly one cycle, with err as determined, and the next state SHALL be IDLE unconditionally.
REQ-015 ready and err SHALL be 0 in IDLE and REQ.
REQ-016 Minimum latency SHALL be: enable sampled at edge N, mem_req high after edge N+1, ack in that cycle, ready high after edge N+2.
REQ-017 If enable falls while in REQ, the access SHALL still complete and ready SHALL still pulse; no memory request is ever abandoned except by timeout or reset.
REQ-018 mem_ack in IDLE or DONE SHALL be ignored.
REQ-019 After DONE, a still-asserted enable SHALL be treated in IDLE as a new request with its current inputs.
REQ-020 Since the CPU advances on ready, there SHALL be one IDLE bubble between back-to-back accesses.

Reset
REQ-021 On a clk edge with rst_n=0, the block SHALL go to IDLE and set ready, err, mem_req and mem_we to 0, mem_be to 4'h0, and mem_addr, mem_wdata, rdata and the wait counter to 0.
REQ-022 Reset asserted during REQ SHALL drop mem_req at that edge; a later mem_ack SHALL be ignored.

Verification
REQ-023 Load word: addr=0x100, size=2, write=0; ack in the first REQ cycle with mem_rdata=0x12345678 -> mem_addr=0x100, mem_be=4'hF, ready with rdata=0x12345678 two cycles after enable, err=0.
REQ-024 Byte store: addr=0x203, size=0, wdata=0xAB; ack after 3 wait cycles -> mem_be=4'b1000, mem_wdata=0xAB000000, mem_we=1, ready after edge N+5.
REQ-025 Misaligned half: addr=0x101, size=1 -> mem_req never asserted; ready=1 and err=1 one cycle after enable.
REQ-026 Timeout with TIMEOUT=4 and no ack -> mem_req high for exactly 4 cycles, then ready=1, err=1, rdata=0; ack exactly at cycle 4 -> err=0.
REQ-027 rst_n=0 in the second REQ cycle -> mem_req=0 after that edge; a stale mem_ack one cycle later produces no ready.
REQ-028 Back-to-back: enable held for two loads at 0x0 and 0x4, both acked immediately -> ready pulses two cycles after each sampled enable, with one IDLE cycle between the DONE of the first access and the sampling of the second.
